// File: rtl/serial_add_sub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_add_sub: bit-serial WIDTH-bit adder/subtractor, LSB first,     |
// | with valid/ready handshakes on operands and result.                  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module serial_add_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             m,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             busy
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic             r_mode;
   logic             r_c;
   logic [CW-1:0]    r_cnt;

   logic w_a0;
   logic w_b0;
   logic w_s;
   logic w_c_next;

   assign w_a0     = r_a_sh[0];
   assign w_b0     = r_b_sh[0];
   assign w_s      = w_a0 ^ w_b0 ^ r_c;
   // Borrow uses the complemented minuend bit; otherwise identical to carry.
   assign w_c_next = r_mode ? ((~w_a0 & w_b0) | (r_c & ~(w_a0 ^ w_b0)))
                            : (( w_a0 & w_b0) | (r_c &  (w_a0 ^ w_b0)));

   assign cout = r_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_a_sh    <= '0;
         r_b_sh    <= '0;
         r_mode    <= 1'b0;
         r_c       <= 1'b0;
         r_cnt     <= '0;
         result    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a_sh   <= a;
                  r_b_sh   <= b;
                  r_mode   <= m;
                  r_c      <= 1'b0;
                  r_cnt    <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  r_state  <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_a_sh <= r_a_sh >> 1;
               r_b_sh <= r_b_sh >> 1;
               result <= {w_s, result[WIDTH-1:1]};
               r_c    <= w_c_next;
               r_cnt  <= r_cnt + CW'(1);
               if (r_cnt == C_LAST) begin
                  out_valid <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
